fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Control-side partner of the EX stage. It generates the `aluselectA`/`aluselectB` forwarding selects that the EX stage muxes consume.
- It detects load-use hazards and issues stall and bubble controls to IF/ID/EX.
- It keeps its own shadow copy of destination-register state for the EX, MEM and WB stages, shifting in lockstep with the datapath pipeline registers. It sits beside the decode stage; its registered outputs line up with the cycle in which the instruction occupies EX.

Parameters:
- RADDR_W, 5, register-address width.
- ZERO_REG, 0, register index that is never forwarded and never causes a stall.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  decode slot holds a real instruction
- id_rs  input  RADDR_W  source A register of the decoding instruction
- id_rt  input  RADDR_W  source B register of the decoding instruction
- id_uses_rs  input  1  instruction reads rs
- id_uses_rt  input  1  instruction reads rt through the ALU B path
- id_rw  input  RADDR_W  final destination register (after RegDst/Jal resolution)
- id_regwrite  input  1  instruction writes the register file
- id_memtoreg  input  1  instruction is a load
- flush  input  1  kill the decoding instruction (taken jump/branch)
- freeze  input  1  global hold from the memory side; all state holds
- stall  output  1  hold PC and the IF/ID register this cycle (combinational)
- bubble  output  1  force zero controls into the EX register at the next edge (combinational)
- aluselectA  output  2  0=BusA, 1=priorALUresult, 2=ALUwriteback, 3 unused (registered)
- aluselectB  output  2  same encoding for the B operand (registered)
- stat_stalls  output  CNT_W  load-use stall count (only with the optional feature)
- stat_fwds  output  CNT_W  forwarded-operand count (only with the optional feature)

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - all shadow entries ex/mem/wb have valid=0, rw=0, regwrite=0, memtoreg=0;
  - aluselectA=aluselectB=0;
  - stall=bubble=0;
  - statistics counters=0.
- Reset asserted mid-operation discards all in-flight hazard state. No stall survives reset.
- Each shadow entry holds: valid, rw, regwrite, memtoreg.
- A source register matches an entry when all of the following hold: the source's uses flag is 1, the entry is valid, entry.regwrite=1, entry.rw==source, and source!=ZERO_REG.
- Load-use hazard (combinational): id_valid & !flush & the ex entry has memtoreg=1 & rs or rt matches the ex entry.
  - When the hazard is present: stall=1, bubble=1.
  - Otherwise: stall=0, bubble=flush&id_valid.
- Flush and a hazard in the same cycle: flush wins; stall=0, bubble=1.
- On a rising edge with freeze=0:
  - wb<=mem and mem<=ex.
  - ex<=bubble ? empty : {id_valid,id_rw,id_regwrite,id_memtoreg}.
  - aluselectA/B are computed from the ID-time matches:
    - 1 if the source matches the ex entry (result arrives as priorALUresult);
    - else 2 if the source matches the mem entry (ALUwriteback);
    - else 0.
  - Priority: youngest producer (ex) over mem.
  - When bubble=1, both selects register 0.
- A match against the wb entry is not forwarded. The register file writes in the first half-cycle and reads in the second.
- freeze=1 holds every register, including the selects. stall and bubble are forced to 0 during freeze.
- Latency:
  - selects: one cycle, valid exactly while the instruction is in EX;
  - a load-use stall lasts exactly one cycle. After the bubble, the load sits in mem, so the consumer gets select 2.
- Back-to-back loads to the same register with a consumer after them: one stall only.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined:
  - stat_stalls increments on every non-frozen edge with stall=1;
  - stat_fwds increments by the number of nonzero selects being registered (0, 1 or 2);
  - both counters saturate at all-ones.
- When undefined: the counters are not built and both ports tie to 0.

Test Plan:
- Sequence `add r3,r1,r2` then `sub r4,r3,r5` -> on the sub's EX cycle aluselectA=1, aluselectB=0, stall never 1.
- Sequence `add r3`, `nop`, `or r6,r1,r3` -> on the or's EX cycle aluselectB=2, aluselectA=0.
- Sequence `lw r3`, `add r4,r3,r3` -> stall=1 and bubble=1 for exactly one cycle. The next cycle stall=0, and on the add's EX cycle aluselectA=aluselectB=2.
- Producer writes r0, consumer reads r0 -> selects 0, no stall. A producer with regwrite=0 and matching rw -> selects 0.
- load-use hazard coinciding with flush=1 -> stall=0, bubble=1, next-cycle selects 0. freeze=1 for 3 cycles mid-sequence -> selects and shadow state unchanged, and forwarding resumes correctly afterwards.
- rst_n pulled low while stall=1 -> stall, bubble and selects go to 0 immediately. With FWD_HAZARD_STATS_EN defined, after the third scenario stat_stalls=1 and stat_fwds=2.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control beside ID; selects registered one cycle (valid in EX), stall/bubble combinational.
// freeze holds all state and masks stall/bubble; optional counters under FWD_HAZARD_STATS_EN.
module fwd_hazard_unit #(
   parameter int RADDR_W  = 5,
   parameter int ZERO_REG = 0,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               id_valid,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic               id_uses_rs,
   input  logic               id_uses_rt,
   input  logic [RADDR_W-1:0] id_rw,
   input  logic               id_regwrite,
   input  logic               id_memtoreg,
   input  logic               flush,
   input  logic               freeze,
   output logic               stall,
   output logic               bubble,
   output logic [1:0]         aluselectA,
   output logic [1:0]         aluselectB,
   output logic [CNT_W-1:0]   stat_stalls,
   output logic [CNT_W-1:0]   stat_fwds
);

   localparam logic [RADDR_W-1:0] ZERO = RADDR_W'(ZERO_REG);

   typedef struct packed {
      logic               valid;
      logic [RADDR_W-1:0] rw;
      logic               regwrite;
   } prod_t;

   // Only the EX entry needs the load flag; MEM results are already forwardable.
   // A WB producer is served by the write-first register file, so no WB copy is kept.
   prod_t exProd, memProd;
   logic  exLoad;

   logic       exMatchRs, exMatchRt, memMatchRs, memMatchRt, loadUse;
   logic [1:0] selANext, selBNext;

   function automatic logic srcMatch(input logic uses, input logic [RADDR_W-1:0] src,
                                     input prod_t p);
      return uses & p.valid & p.regwrite & (p.rw == src) & (src != ZERO);
   endfunction

   always_comb begin
      exMatchRs  = srcMatch(id_uses_rs, id_rs, exProd);
      exMatchRt  = srcMatch(id_uses_rt, id_rt, exProd);
      memMatchRs = srcMatch(id_uses_rs, id_rs, memProd);
      memMatchRt = srcMatch(id_uses_rt, id_rt, memProd);
      loadUse    = id_valid & ~flush & exLoad & (exMatchRs | exMatchRt);
      stall      = ~freeze & loadUse;
      bubble     = ~freeze & (loadUse | (flush & id_valid));
      selANext   = 2'd0;
      selBNext   = 2'd0;
      if (!bubble) begin
         // Youngest producer wins: EX result over MEM result.
         if (exMatchRs)       selANext = 2'd1;
         else if (memMatchRs) selANext = 2'd2;
         if (exMatchRt)       selBNext = 2'd1;
         else if (memMatchRt) selBNext = 2'd2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exProd     <= '0;
         exLoad     <= 1'b0;
         memProd    <= '0;
         aluselectA <= 2'd0;
         aluselectB <= 2'd0;
      end else if (!freeze) begin
         memProd    <= exProd;
         aluselectA <= selANext;
         aluselectB <= selBNext;
         if (bubble) begin
            exProd <= '0;
            exLoad <= 1'b0;
         end else begin
            exProd <= '{valid: id_valid, rw: id_rw, regwrite: id_regwrite};
            exLoad <= id_memtoreg;
         end
      end
   end

`ifdef FWD_HAZARD_STATS_EN
   logic [1:0]     fwdInc;
   logic [CNT_W:0] fwdSum;

   always_comb begin
      fwdInc = {1'b0, selANext != 2'd0} + {1'b0, selBNext != 2'd0};
      fwdSum = {1'b0, stat_fwds} + {{(CNT_W-1){1'b0}}, fwdInc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_stalls <= '0;
         stat_fwds   <= '0;
      end else if (!freeze) begin
         if (stall && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
         stat_fwds <= fwdSum[CNT_W] ? '1 : fwdSum[CNT_W-1:0];
      end
   end
`else
   assign stat_stalls = '0;
   assign stat_fwds   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit: one continuous instruction stream plus a reset-during-stall sequence.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memtoreg, flush, freeze;
   logic [4:0]  id_rs, id_rt, id_rw;
   logic        stall, bubble;
   logic [1:0]  aluselectA, aluselectB;
   logic [15:0] stat_stalls, stat_fwds;

   int checks   = 0;
   int failures = 0;

`ifdef FWD_HAZARD_STATS_EN
   localparam int EXP_STALLS = 1;
   localparam int EXP_FWDS   = 2;
`else
   localparam int EXP_STALLS = 0;
   localparam int EXP_FWDS   = 0;
`endif

   fwd_hazard_unit dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rw(id_rw),
      .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .flush(flush), .freeze(freeze),
      .stall(stall), .bubble(bubble), .aluselectA(aluselectA), .aluselectB(aluselectB),
      .stat_stalls(stat_stalls), .stat_fwds(stat_fwds)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [4:0] rs, rt;
      logic       urs, urt;
      logic [4:0] rw;
      logic       rwr, mtr, fl, fz;
      logic       eStall, eBubble;
      logic [1:0] eSelA, eSelB;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic vld, input int rs, input int rt, input logic urs,
                               input logic urt, input int rw, input logic rwr, input logic mtr,
                               input logic fl, input logic fz, input logic st, input logic bu,
                               input int sa, input int sb);
      vec_t v;
      v.vld = vld; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.rw = 5'(rw);
      v.rwr = rwr; v.mtr = mtr; v.fl = fl; v.fz = fz;
      v.eStall = st; v.eBubble = bu; v.eSelA = 2'(sa); v.eSelB = 2'(sb);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      id_valid = v.vld; id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
      id_rw = v.rw; id_regwrite = v.rwr; id_memtoreg = v.mtr; flush = v.fl; freeze = v.fz;
   endtask

   // Inputs change on the falling edge; stall/bubble sampled before the rising edge,
   // selects sampled just after it (instruction now in EX).
   task automatic runVec(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      #1;
      chk({tag, " stall"}, 32'(stall), 32'(v.eStall));
      chk({tag, " bubble"}, 32'(bubble), 32'(v.eBubble));
      @(posedge clk);
      #1;
      chk({tag, " selA"}, 32'(aluselectA), 32'(v.eSelA));
      chk({tag, " selB"}, 32'(aluselectB), 32'(v.eSelB));
   endtask

   initial begin
      vec_t nop, cons;
      nop = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);

      // load-use: lw r3 ; add r4,r3,r3 (stalled once, then fed from MEM)
      tbl.push_back(mk(1,1,0,1,0,3,1,1,0,0, 0,0,0,0));   // 0
      tbl.push_back(mk(1,3,3,1,1,4,1,0,0,0, 1,1,0,0));   // 1
      tbl.push_back(mk(1,3,3,1,1,4,1,0,0,0, 0,0,2,2));   // 2
      tbl.push_back(nop); tbl.push_back(nop);            // 3,4
      // add r3,r1,r2 ; sub r4,r3,r5
      tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0));   // 5
      tbl.push_back(mk(1,3,5,1,1,4,1,0,0,0, 0,0,1,0));   // 6
      tbl.push_back(nop); tbl.push_back(nop);            // 7,8
      // add r3 ; nop ; or r6,r1,r3 ; and r7,r3,r3 (r3 producer now in WB)
      tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0));   // 9
      tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,0));   // 10
      tbl.push_back(mk(1,1,3,1,1,6,1,0,0,0, 0,0,0,2));   // 11
      tbl.push_back(mk(1,3,3,1,1,7,1,0,0,0, 0,0,0,0));   // 12
      tbl.push_back(nop); tbl.push_back(nop);            // 13,14
      // r0 producers, regwrite=0 producer, uses-flag gating
      tbl.push_back(mk(1,1,0,1,0,0,1,1,0,0, 0,0,0,0));   // 15 lw r0
      tbl.push_back(mk(1,0,0,1,1,5,1,0,0,0, 0,0,0,0));   // 16 add r5,r0,r0
      tbl.push_back(mk(1,1,2,1,1,7,0,0,0,0, 0,0,0,0));   // 17 rw=7 regwrite=0
      tbl.push_back(mk(1,7,7,1,1,8,1,0,0,0, 0,0,0,0));   // 18 vs EX
      tbl.push_back(mk(1,7,7,1,1,8,1,0,0,0, 0,0,0,0));   // 19 vs MEM
      tbl.push_back(mk(1,1,2,1,1,9,1,0,0,0, 0,0,0,0));   // 20 add r9
      tbl.push_back(mk(1,9,9,0,1,10,1,0,0,0, 0,0,0,1));  // 21 rs unused
      tbl.push_back(nop); tbl.push_back(nop);            // 22,23
      // load-use coinciding with flush
      tbl.push_back(mk(1,1,0,1,0,3,1,1,0,0, 0,0,0,0));   // 24 lw r3
      tbl.push_back(mk(1,3,3,1,1,4,1,0,1,0, 0,1,0,0));   // 25 flushed add r4
      tbl.push_back(mk(1,4,1,1,1,6,1,0,0,0, 0,0,0,0));   // 26 killed r4 not forwarded
      tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 0,0,0,0));   // 27 flush on empty slot
      tbl.push_back(nop);                                // 28
      // freeze for 3 cycles with a pending load-use
      tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0));   // 29 add r3
      tbl.push_back(mk(1,3,5,1,1,4,1,0,0,0, 0,0,1,0));   // 30 sub r4,r3,r5
      tbl.push_back(mk(1,4,0,1,0,5,1,1,0,0, 0,0,1,0));   // 31 lw r5,0(r4)
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(1,5,4,1,1,6,1,0,0,1, 0,0,1,0)); // 32-34 frozen
      tbl.push_back(mk(1,5,4,1,1,6,1,0,0,0, 1,1,0,0));   // 35
      tbl.push_back(mk(1,5,4,1,1,6,1,0,0,0, 0,0,2,0));   // 36 r4 in WB not forwarded
      tbl.push_back(nop); tbl.push_back(nop);            // 37,38

      rst_n = 1'b0;
      drive(nop);
      #7;
      chk("reset stall", 32'(stall), 0);
      chk("reset bubble", 32'(bubble), 0);
      chk("reset selA", 32'(aluselectA), 0);
      chk("reset selB", 32'(aluselectB), 0);
      chk("reset stat_stalls", 32'(stat_stalls), 0);
      chk("reset stat_fwds", 32'(stat_fwds), 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         runVec(tbl[i], $sformatf("v%0d", i));
         if (i == 2) begin
            chk("stat_stalls after load-use", 32'(stat_stalls), 32'(EXP_STALLS));
            chk("stat_fwds after load-use", 32'(stat_fwds), 32'(EXP_FWDS));
         end
      end

      // Reset while a load-use stall is asserted
      runVec(mk(1,1,2,1,1,3,1,0,0,0, 0,0,0,0), "rs add");
      runVec(mk(1,3,0,1,0,5,1,1,0,0, 0,0,1,0), "rs lw");
      cons = mk(1,5,5,1,1,6,1,0,0,0, 1,1,0,0);
      @(negedge clk);
      drive(cons);
      #1;
      chk("pre-reset stall", 32'(stall), 1);
      chk("pre-reset bubble", 32'(bubble), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid-reset stall", 32'(stall), 0);
      chk("mid-reset bubble", 32'(bubble), 0);
      chk("mid-reset selA", 32'(aluselectA), 0);
      chk("mid-reset selB", 32'(aluselectB), 0);
      chk("mid-reset stat_stalls", 32'(stat_stalls), 0);
      chk("mid-reset stat_fwds", 32'(stat_fwds), 0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset selA", 32'(aluselectA), 0);
      chk("post-reset selB", 32'(aluselectB), 0);
      chk("post-reset stall", 32'(stall), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
